// File: rtl/cpu_interlock_pkg.sv
// Shared definitions for the pipeline interlock: register-file geometry,
// hazard-cause encoding for debug, and a one-hot decode helper.
package cpu_interlock_pkg;

    localparam int REG_IDX_W   = 4;
    localparam int NUM_REGS    = 16;
    localparam int NUM_HAZARDS = 5;

    typedef enum logic [2:0] {
        HZ_RAW_A  = 3'd0,
        HZ_RAW_B  = 3'd1,
        HZ_WAW    = 3'd2,
        HZ_FULL   = 3'd3,
        HZ_MCBUSY = 3'd4
    } hazard_cause_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/cpu_mc_counter.sv
// Busy countdown for multi-cycle ops: loads the extra latency on issue,
// then counts down once per cycle; busy while nonzero.
module cpu_mc_counter
    import cpu_interlock_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] lat_i,
    output logic         busy_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= lat_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/cpu_interlock.sv
// Pipeline interlock: scoreboard of in-flight register writes, outstanding
// write limit and multi-cycle busy gate, producing the fetch/decode stall.
module cpu_interlock
    import cpu_interlock_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter bit WB_BYPASS       = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic [REG_IDX_W-1:0] issue_rA_i,
    input  logic [REG_IDX_W-1:0] issue_rB_i,
    input  logic                 issue_readA_i,
    input  logic                 issue_readB_i,
    input  logic                 issue_we_i,
    input  logic [REG_IDX_W-1:0] issue_wi_i,
    input  logic                 issue_mc_i,
    input  logic [3:0]           issue_lat_i,
    input  logic                 wb_valid_i,
    input  logic [REG_IDX_W-1:0] wb_wi_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 issue_ok_o,
    output logic [NUM_REGS-1:0]  pending_o,
    output logic [3:0]           outstanding_o,
    output logic                 busy_o
);

    logic [NUM_REGS-1:0]    pending_q;
    logic [3:0]             outstanding_q;
    logic [NUM_HAZARDS-1:0] hazard;
    logic                   mc_busy;
    logic                   wb_retire;
    logic                   accept;
    logic                   do_set;
    logic                   do_clr;
    logic [NUM_REGS-1:0]    set_vec;
    logic [NUM_REGS-1:0]    clr_vec;

    // A writeback only retires something when its register is actually pending.
    assign wb_retire = wb_valid_i && pending_q[wb_wi_i];

    always_comb begin
        hazard            = '0;
        hazard[HZ_RAW_A]  = issue_readA_i && pending_q[issue_rA_i]
                            && !(WB_BYPASS && wb_valid_i && (wb_wi_i == issue_rA_i));
        hazard[HZ_RAW_B]  = issue_readB_i && pending_q[issue_rB_i]
                            && !(WB_BYPASS && wb_valid_i && (wb_wi_i == issue_rB_i));
        hazard[HZ_WAW]    = issue_we_i && pending_q[issue_wi_i]
                            && !(wb_valid_i && (wb_wi_i == issue_wi_i));
        // Only a real retire frees a slot, so the count can never pass the limit.
        hazard[HZ_FULL]   = issue_we_i && (outstanding_q == 4'(MAX_OUTSTANDING))
                            && !wb_retire;
        hazard[HZ_MCBUSY] = mc_busy;
    end

    assign stall_o    = issue_valid_i && (|hazard);
    assign issue_ok_o = issue_valid_i && !stall_o;

    assign accept  = issue_ok_o && !flush_i;
    assign do_set  = accept && issue_we_i;
    assign do_clr  = wb_retire && !flush_i;
    assign set_vec = do_set ? reg_onehot(issue_wi_i) : '0;
    assign clr_vec = do_clr ? reg_onehot(wb_wi_i) : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending_q     <= '0;
            outstanding_q <= '0;
        end else if (flush_i) begin
            pending_q     <= '0;
            outstanding_q <= '0;
        end else begin
            // Set is applied after clear, so a same-register set/clear keeps the bit.
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            case ({do_set, do_clr})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    cpu_mc_counter #(.W(4)) u_mc_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .load_i  (accept && issue_mc_i),
        .lat_i   (issue_lat_i),
        .busy_o  (mc_busy)
    );

    assign pending_o     = pending_q;
    assign outstanding_o = outstanding_q;
    assign busy_o        = mc_busy;

endmodule

// File: tb/tb_cpu_interlock.sv
// Directed bench for cpu_interlock (MAX_OUTSTANDING=4, WB_BYPASS=1) with
// hand-computed expectations checked by immediate assertions.
module tb_cpu_interlock;

    logic        clk_i;
    logic        rst_i;
    logic        issue_valid_i;
    logic [3:0]  issue_rA_i;
    logic [3:0]  issue_rB_i;
    logic        issue_readA_i;
    logic        issue_readB_i;
    logic        issue_we_i;
    logic [3:0]  issue_wi_i;
    logic        issue_mc_i;
    logic [3:0]  issue_lat_i;
    logic        wb_valid_i;
    logic [3:0]  wb_wi_i;
    logic        flush_i;
    logic        stall_o;
    logic        issue_ok_o;
    logic [15:0] pending_o;
    logic [3:0]  outstanding_o;
    logic        busy_o;

    int checks;
    int errors;

    cpu_interlock #(.MAX_OUTSTANDING(4), .WB_BYPASS(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .issue_rA_i    (issue_rA_i),
        .issue_rB_i    (issue_rB_i),
        .issue_readA_i (issue_readA_i),
        .issue_readB_i (issue_readB_i),
        .issue_we_i    (issue_we_i),
        .issue_wi_i    (issue_wi_i),
        .issue_mc_i    (issue_mc_i),
        .issue_lat_i   (issue_lat_i),
        .wb_valid_i    (wb_valid_i),
        .wb_wi_i       (wb_wi_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .issue_ok_o    (issue_ok_o),
        .pending_o     (pending_o),
        .outstanding_o (outstanding_o),
        .busy_o        (busy_o)
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        issue_valid_i = 1'b0;
        issue_rA_i    = 4'd0;
        issue_rB_i    = 4'd0;
        issue_readA_i = 1'b0;
        issue_readB_i = 1'b0;
        issue_we_i    = 1'b0;
        issue_wi_i    = 4'd0;
        issue_mc_i    = 1'b0;
        issue_lat_i   = 4'd0;
        wb_valid_i    = 1'b0;
        wb_wi_i       = 4'd0;
        flush_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_write(input logic [3:0] wi);
        clear_inputs();
        issue_valid_i = 1'b1;
        issue_we_i    = 1'b1;
        issue_wi_i    = wi;
    endtask

    task automatic drive_wb(input logic [3:0] wi);
        wb_valid_i = 1'b1;
        wb_wi_i    = wi;
    endtask

    task automatic drive_mc(input logic [3:0] lat);
        clear_inputs();
        issue_valid_i = 1'b1;
        issue_mc_i    = 1'b1;
        issue_lat_i   = lat;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state
        check("rst_pending", 32'(pending_o), 32'h0);
        check("rst_outstanding", 32'(outstanding_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // RAW on r3, released by a bypassed writeback
        drive_write(4'd3);
        settle();
        check("raw_first_ok", 32'(issue_ok_o), 32'd1);
        tick();
        check("raw_pending3", 32'(pending_o), 32'h0008);
        check("raw_out1", 32'(outstanding_o), 32'd1);
        clear_inputs();
        issue_valid_i = 1'b1;
        issue_readA_i = 1'b1;
        issue_rA_i    = 4'd3;
        settle();
        check("raw_stall_c1", 32'(stall_o), 32'd1);
        check("raw_ok_c1", 32'(issue_ok_o), 32'd0);
        tick();
        check("raw_stall_c2", 32'(stall_o), 32'd1);
        drive_wb(4'd3);
        settle();
        check("raw_bypass_stall", 32'(stall_o), 32'd0);
        check("raw_bypass_ok", 32'(issue_ok_o), 32'd1);
        tick();
        check("raw_pending_clr", 32'(pending_o), 32'h0000);
        check("raw_out0", 32'(outstanding_o), 32'd0);

        // RAW through source B, no writeback
        drive_write(4'd9);
        tick();
        clear_inputs();
        issue_valid_i = 1'b1;
        issue_readB_i = 1'b1;
        issue_rB_i    = 4'd9;
        settle();
        check("rawb_stall", 32'(stall_o), 32'd1);
        clear_inputs();
        drive_wb(4'd9);
        tick();
        check("rawb_retired", 32'(pending_o), 32'h0000);

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            drive_write(4'(r));
            tick();
        end
        check("full_out4", 32'(outstanding_o), 32'd4);
        check("full_pend", 32'(pending_o), 32'h001E);
        drive_write(4'd5);
        settle();
        check("full_stall", 32'(stall_o), 32'd1);
        drive_wb(4'd1);
        settle();
        check("full_release", 32'(stall_o), 32'd0);
        tick();
        check("full_pend_after", 32'(pending_o), 32'h003C);
        check("full_out_after", 32'(outstanding_o), 32'd4);

        // WAW on a pending destination
        drive_write(4'd4);
        settle();
        check("waw_stall", 32'(stall_o), 32'd1);

        // Free two slots, then set and clear r7 in one cycle
        clear_inputs();
        drive_wb(4'd2);
        tick();
        clear_inputs();
        drive_wb(4'd3);
        tick();
        check("drain_pend", 32'(pending_o), 32'h0030);
        check("drain_out", 32'(outstanding_o), 32'd2);
        drive_write(4'd7);
        tick();
        check("r7_pend", 32'(pending_o), 32'h00B0);
        drive_write(4'd7);
        drive_wb(4'd7);
        settle();
        check("setclr_ok", 32'(issue_ok_o), 32'd1);
        tick();
        check("setclr_pend", 32'(pending_o), 32'h00B0);
        check("setclr_out", 32'(outstanding_o), 32'd3);

        // Flush with pending=0x00F0 and busy counter at 2
        drive_write(4'd6);
        tick();
        drive_mc(4'd2);
        tick();
        check("fl_pre_pend", 32'(pending_o), 32'h00F0);
        check("fl_pre_busy", 32'(busy_o), 32'd1);
        clear_inputs();
        flush_i = 1'b1;
        tick();
        check("fl_pend", 32'(pending_o), 32'h0000);
        check("fl_out", 32'(outstanding_o), 32'd0);
        check("fl_busy", 32'(busy_o), 32'd0);

        // An accepted-looking issue during flush leaves no trace
        drive_write(4'd9);
        issue_mc_i  = 1'b1;
        issue_lat_i = 4'd5;
        drive_wb(4'd4);
        flush_i = 1'b1;
        settle();
        check("fl_issue_ok", 32'(issue_ok_o), 32'd1);
        tick();
        check("fl_trace_pend", 32'(pending_o), 32'h0000);
        check("fl_trace_out", 32'(outstanding_o), 32'd0);
        check("fl_trace_busy", 32'(busy_o), 32'd0);

        // Multi-cycle op with lat=3
        drive_mc(4'd3);
        tick();
        clear_inputs();
        issue_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mc_busy", 32'(busy_o), 32'd1);
            check("mc_stall", 32'(stall_o), 32'd1);
            tick();
        end
        check("mc_done_busy", 32'(busy_o), 32'd0);
        check("mc_done_stall", 32'(stall_o), 32'd0);
        drive_mc(4'd0);
        tick();
        check("mc_lat0_busy", 32'(busy_o), 32'd0);

        // Async reset mid-countdown with pending=0x8001
        drive_write(4'd15);
        tick();
        drive_write(4'd0);
        tick();
        drive_mc(4'd4);
        tick();
        clear_inputs();
        check("ar_pre_pend", 32'(pending_o), 32'h8001);
        check("ar_pre_busy", 32'(busy_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("ar_pend", 32'(pending_o), 32'h0000);
        check("ar_out", 32'(outstanding_o), 32'd0);
        check("ar_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Writeback to a non-pending register is ignored
        drive_write(4'd2);
        tick();
        clear_inputs();
        drive_wb(4'd5);
        tick();
        check("wbnp_pend", 32'(pending_o), 32'h0004);
        check("wbnp_out", 32'(outstanding_o), 32'd1);
        clear_inputs();
        drive_wb(4'd2);
        tick();
        clear_inputs();
        drive_wb(4'd2);
        tick();
        check("wb_no_underflow", 32'(outstanding_o), 32'd0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
